// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the RV32I multi-cycle main controller:
//   - RV32I opcode constants (instruction bits 6:0)
//   - ALUOp encodings driven into the ALU operation decoder
//   - controller state enum
//   - instruction-class enum produced by mc_op_class
//   - aluop_of(): class -> ALUOp mapping
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;  // LW / SW / AUIPC (add)
    localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RI  = 2'b10;  // R / I-type, funct fields decide
    localparam logic [1:0] ALUOP_JL  = 2'b11;  // JAL / LUI

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILL   = 4'd0,
        CLS_R     = 4'd1,
        CLS_I     = 4'd2,
        CLS_LW    = 4'd3,
        CLS_SW    = 4'd4,
        CLS_BR    = 4'd5,
        CLS_JAL   = 4'd6,
        CLS_LUI   = 4'd7,
        CLS_AUIPC = 4'd8
    } iclass_t;

    function automatic logic [1:0] aluop_of(input iclass_t cls);
        logic [1:0] op;
        op = ALUOP_MEM;
        case (cls)
            CLS_R, CLS_I:     op = ALUOP_RI;
            CLS_BR:           op = ALUOP_BR;
            CLS_JAL, CLS_LUI: op = ALUOP_JL;
            default:          op = ALUOP_MEM;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_op_class.sv
// -----------------------------------------------------------------------------
// mc_op_class
// Combinational opcode classifier.
// Ports:
//   opcode : in  [OPC_W-1:0]  instruction bits 6:0
//   cls    : out iclass_t     instruction class (CLS_ILL for unknown opcodes)
//   legal  : out              1 when the opcode is one of the supported RV32I ops
// -----------------------------------------------------------------------------
module mc_op_class
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic [OPC_W-1:0] opcode,
    output iclass_t          cls,
    output logic             legal
);

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OPC_R:     cls = CLS_R;
            OPC_I:     cls = CLS_I;
            OPC_LW:    cls = CLS_LW;
            OPC_SW:    cls = CLS_SW;
            OPC_BEQ:   cls = CLS_BR;
            OPC_JAL:   cls = CLS_JAL;
            OPC_LUI:   cls = CLS_LUI;
            OPC_AUIPC: cls = CLS_AUIPC;
            default:   cls = CLS_ILL;
        endcase
    end

    assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/mc_main_controller.sv
// -----------------------------------------------------------------------------
// mc_main_controller
// Multi-cycle main control FSM for the RV32I datapath. Accepts one instruction
// at a time, classifies it, and walks it through DECODE/EXEC/MEM/WB while
// driving ALUOp/Funct3/Funct7 to the ALU decoder and the datapath enables.
//
// Optional build macro: MC_MEM_TIMEOUT_EN
//   Adds a MEM-state watchdog (TIMEOUT_CYCLES) and the mem_err output.
//
// Ports:
//   clk, reset            : clock (rising edge), async active-high reset
//   instr_valid/ready     : instruction handshake (see below)
//   opcode/funct3_in/funct7_in : instruction fields, latched on accept
//   mem_ack               : data memory done, only looked at in MEM
//   ALUOp/Funct3/Funct7   : registered ALU decoder controls (set DECODE->EXEC)
//   ALUSrc                : 1 = immediate operand, registered with the above
//   MemRead/MemWrite      : MEM-state strobes for LW / SW
//   RegWrite/MemtoReg     : WB-state strobe, MemtoReg = 1 for LW
//   Branch/Jump           : EXEC-state strobes for BEQ / JAL
//   illegal               : one-cycle pulse in DECODE for an unknown opcode
//   busy                  : controller not in IDLE
//   mem_err               : (MC_MEM_TIMEOUT_EN only) one-cycle MEM timeout pulse
//   state_dbg             : current FSM state, for observation only
//
// Handshake: instr_ready is high exactly in IDLE. An instruction is accepted on
// a rising edge where instr_valid && instr_ready; instr_valid in any other
// state is ignored and nothing is buffered.
// -----------------------------------------------------------------------------
module mc_main_controller
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 7
`ifdef MC_MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3_in,
    input  logic [6:0]       funct7_in,
    input  logic             mem_ack,
    output logic [1:0]       ALUOp,
    output logic [2:0]       Funct3,
    output logic [6:0]       Funct7,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             Branch,
    output logic             Jump,
    output logic             illegal,
    output logic             busy,
`ifdef MC_MEM_TIMEOUT_EN
    output logic             mem_err,
`endif
    output logic [2:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic [2:0]       f3_q;
    logic [6:0]       f7_q;
    iclass_t          cls;
    logic             legal;
    logic             accept;
    logic             dec_to_exec;

    logic [2:0]       f3_san;
    logic [6:0]       f7_san;
    logic             alusrc_d;

    // Classification works on the latched opcode so every strobe is a pure
    // function of state and the instruction that was accepted.
    mc_op_class #(.OPC_W(OPC_W)) u_op_class (
        .opcode (opc_q),
        .cls    (cls),
        .legal  (legal)
    );

    assign accept      = (state_q == ST_IDLE) && instr_valid;
    assign dec_to_exec = (state_q == ST_DECODE) && legal;

`ifdef MC_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Fires in the MEM cycle whose missing ack would bring the count of
    // ack-less MEM cycles up to TIMEOUT_CYCLES.
    assign tmo_hit = (state_q == ST_MEM) && !mem_ack &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Held at zero outside MEM, which clears it on every MEM entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= tmo_hit;
            if (state_q != ST_MEM) begin
                tmo_cnt <= '0;
            end else if (!mem_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction field latch: holds until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q <= '0;
            f3_q  <= '0;
            f7_q  <= '0;
        end else if (accept) begin
            opc_q <= opcode;
            f3_q  <= funct3_in;
            f7_q  <= funct7_in;
        end
    end

    // Next state and Moore strobes
    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                    illegal = 1'b1;
                end
            end
            ST_EXEC: begin
                Branch = (cls == CLS_BR);
                Jump   = (cls == CLS_JAL);
                case (cls)
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    CLS_BR:         state_d = ST_IDLE;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                MemRead  = (cls == CLS_LW);
                MemWrite = (cls == CLS_SW);
                if (mem_ack) begin
                    state_d = (cls == CLS_LW) ? ST_WB : ST_IDLE;
                end
`ifdef MC_MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls == CLS_LW);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Funct field sanitising. I-type only forwards funct7 for shifts so that
    // an ADDI with immediate bit 30 set is not mistaken for SUB.
    always_comb begin
        f3_san   = 3'b000;
        f7_san   = 7'b0000000;
        alusrc_d = 1'b1;
        case (cls)
            CLS_R: begin
                f3_san   = f3_q;
                f7_san   = f7_q;
                alusrc_d = 1'b0;
            end
            CLS_I: begin
                f3_san = f3_q;
                if (f3_q == 3'b001 || f3_q == 3'b101) f7_san = f7_q;
            end
            CLS_LW, CLS_SW, CLS_AUIPC: begin
                f3_san = 3'b010;
            end
            CLS_BR: begin
                f3_san   = f3_q;
                alusrc_d = 1'b0;
            end
            default: begin
                f3_san = 3'b000;
            end
        endcase
    end

    // ALU controls are captured on DECODE->EXEC and held through MEM/WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUOp  <= '0;
            Funct3 <= '0;
            Funct7 <= '0;
            ALUSrc <= 1'b0;
        end else if (dec_to_exec) begin
            ALUOp  <= aluop_of(cls);
            Funct3 <= f3_san;
            Funct7 <= f7_san;
            ALUSrc <= alusrc_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_main_controller
// Table-driven bench for mc_main_controller plus hand-written sequences for
// reset state, reset in MEM and (with MC_MEM_TIMEOUT_EN) the MEM timeout.
// Cycle numbering inside run_vec: cycle 1 is the first cycle after the accept
// edge (DECODE), cycle 2 is EXEC, MEM starts at cycle 3.
// -----------------------------------------------------------------------------
module tb_mc_main_controller;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [6:0] opcode = '0;
    logic [2:0] funct3_in = '0;
    logic [6:0] funct7_in = '0;
    logic       mem_ack = 1'b0;
    logic [1:0] ALUOp;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg;
    logic       Branch, Jump, illegal, busy;
    logic [2:0] state_dbg;
`ifdef MC_MEM_TIMEOUT_EN
    logic       mem_err;
`endif

`ifdef MC_MEM_TIMEOUT_EN
    mc_main_controller #(.OPC_W(7), .TIMEOUT_CYCLES(4)) dut (
`else
    mc_main_controller #(.OPC_W(7)) dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .funct3_in   (funct3_in),
        .funct7_in   (funct7_in),
        .mem_ack     (mem_ack),
        .ALUOp       (ALUOp),
        .Funct3      (Funct3),
        .Funct7      (Funct7),
        .ALUSrc      (ALUSrc),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .Branch      (Branch),
        .Jump        (Jump),
        .illegal     (illegal),
        .busy        (busy),
`ifdef MC_MEM_TIMEOUT_EN
        .mem_err     (mem_err),
`endif
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];   // {ALUOp, Funct3, Funct7, ALUSrc} expected in EXEC

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         ack_dly;   // MEM cycle (1-based) in which ack is given; 0 = never
        bit         chk_alu;
        logic [1:0] aluop;
        logic [2:0] fo3;
        logic [6:0] fo7;
        logic       alusrc;
        int         lat;       // cycle in which instr_ready is high again
        int         rw_cyc;    // cycle of the RegWrite pulse; 0 = none
        int         mr;        // MemRead cycles
        int         mw;        // MemWrite cycles
        bit         m2r;
        int         br;
        int         jp;
        int         il;
        int         err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input int ack, input bit ca, input logic [1:0] aop,
                                input logic [2:0] fo3, input logic [6:0] fo7, input logic asrc,
                                input int lat, input int rwc, input int mr, input int mw,
                                input bit m2r, input int br, input int jp, input int il, input int err);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.ack_dly = ack; v.chk_alu = ca;
        v.aluop = aop; v.fo3 = fo3; v.fo7 = fo7; v.alusrc = asrc;
        v.lat = lat; v.rw_cyc = rwc; v.mr = mr; v.mw = mw; v.m2r = m2r;
        v.br = br; v.jp = jp; v.il = il; v.err = err;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_vec(input int idx, input vec_t v);
        int rw_n, rw_at, mr_n, mw_n, br_n, jp_n, il_n, il_at, err_n, lat;
        bit m2r_seen, done;
        logic [12:0] alu_exp;
        string tag;
        rw_n = 0; rw_at = 0; mr_n = 0; mw_n = 0; br_n = 0; jp_n = 0;
        il_n = 0; il_at = 0; err_n = 0; lat = 0; m2r_seen = 0; done = 0;
        tag = $sformatf("v%0d", idx);

        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        opcode      = v.opc;
        funct3_in   = v.f3;
        funct7_in   = v.f7;
        mem_ack     = 1'b0;
        if (v.chk_alu) exp_q.push_back({v.aluop, v.fo3, v.fo7, v.alusrc});

        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (instr_ready) begin
                lat  = cyc;
                done = 1'b1;
            end
            if (RegWrite) begin
                rw_n++;
                rw_at = cyc;
                if (MemtoReg) m2r_seen = 1'b1;
            end
            if (MemRead)  mr_n++;
            if (MemWrite) mw_n++;
            if (Branch)   br_n++;
            if (Jump)     jp_n++;
            if (illegal) begin
                il_n++;
                il_at = cyc;
            end
`ifdef MC_MEM_TIMEOUT_EN
            if (mem_err) err_n++;
`endif
            if (cyc == 2 && v.chk_alu) begin
                alu_exp = exp_q.pop_front();
                chk({tag, "_alu_ctrl"}, 32'({ALUOp, Funct3, Funct7, ALUSrc}), 32'(alu_exp));
            end
            if (done) begin
                instr_valid = 1'b0;
                mem_ack     = 1'b0;
                chk({tag, "_idle_strobes"},
                    32'({MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump, illegal, busy}), 32'd0);
            end else begin
                // Garbage on the instruction bus while busy must be ignored
                instr_valid = 1'b1;
                opcode      = 7'h7f;
                funct3_in   = 3'($urandom_range(0, 7));
                funct7_in   = 7'($urandom_range(0, 127));
                mem_ack     = (v.ack_dly > 0) && (cyc == 2 + v.ack_dly);
            end
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;

        chk({tag, "_latency"},   32'(lat),   32'(v.lat));
        chk({tag, "_regwr_cnt"}, 32'(rw_n),  (v.rw_cyc != 0) ? 32'd1 : 32'd0);
        chk({tag, "_regwr_cyc"}, 32'(rw_at), 32'(v.rw_cyc));
        chk({tag, "_memtoreg"},  32'(m2r_seen), 32'(v.m2r));
        chk({tag, "_memread"},   32'(mr_n),  32'(v.mr));
        chk({tag, "_memwrite"},  32'(mw_n),  32'(v.mw));
        chk({tag, "_branch"},    32'(br_n),  32'(v.br));
        chk({tag, "_jump"},      32'(jp_n),  32'(v.jp));
        chk({tag, "_illegal"},   32'(il_n),  32'(v.il));
        if (v.il != 0) chk({tag, "_illegal_cyc"}, 32'(il_at), 32'd1);
`ifdef MC_MEM_TIMEOUT_EN
        chk({tag, "_mem_err"},   32'(err_n), 32'(v.err));
`else
        if (err_n != v.err) chk({tag, "_mem_err"}, 32'(err_n), 32'(v.err));
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // columns: opc f3 f7 ack chk | ALUOp Funct3 Funct7 ALUSrc | lat rw_cyc mr mw m2r br jp il err
        vq.push_back(mk(7'b0110011, 3'b000, 7'b0100000, 0, 1, 2'b10, 3'b000, 7'b0100000, 1'b0, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // SUB
        vq.push_back(mk(7'b0110011, 3'b111, 7'b0000000, 0, 1, 2'b10, 3'b111, 7'b0000000, 1'b0, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // AND
        vq.push_back(mk(7'b0010011, 3'b000, 7'b0100000, 0, 1, 2'b10, 3'b000, 7'b0000000, 1'b1, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // ADDI
        vq.push_back(mk(7'b0010011, 3'b101, 7'b0100000, 0, 1, 2'b10, 3'b101, 7'b0100000, 1'b1, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // SRAI
        vq.push_back(mk(7'b0010011, 3'b110, 7'b1111111, 0, 1, 2'b10, 3'b110, 7'b0000000, 1'b1, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // ORI
        vq.push_back(mk(7'b0000011, 3'b111, 7'b1010101, 3, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 7, 6, 3, 0, 1, 0, 0, 0, 0)); // LW ack +3
        vq.push_back(mk(7'b0000011, 3'b000, 7'b0000000, 1, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 5, 4, 1, 0, 1, 0, 0, 0, 0)); // LW ack on entry
        vq.push_back(mk(7'b0100011, 3'b000, 7'b0000001, 1, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 4, 0, 0, 1, 0, 0, 0, 0, 0)); // SW ack on entry
        vq.push_back(mk(7'b0100011, 3'b100, 7'b0110000, 2, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 5, 0, 0, 2, 0, 0, 0, 0, 0)); // SW ack +2
        vq.push_back(mk(7'b1100011, 3'b001, 7'b0100000, 0, 1, 2'b01, 3'b001, 7'b0000000, 1'b0, 3, 0, 0, 0, 0, 1, 0, 0, 0)); // BEQ-class
        vq.push_back(mk(7'b1101111, 3'b101, 7'b1111111, 0, 1, 2'b11, 3'b000, 7'b0000000, 1'b1, 4, 3, 0, 0, 0, 0, 1, 0, 0)); // JAL
        vq.push_back(mk(7'b0110111, 3'b011, 7'b0100000, 0, 1, 2'b11, 3'b000, 7'b0000000, 1'b1, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // LUI
        vq.push_back(mk(7'b0010111, 3'b110, 7'b0100000, 0, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 4, 3, 0, 0, 0, 0, 0, 0, 0)); // AUIPC
        vq.push_back(mk(7'b1111111, 3'b000, 7'b0000000, 0, 0, 2'b00, 3'b000, 7'b0000000, 1'b0, 2, 0, 0, 0, 0, 0, 0, 1, 0)); // illegal
        vq.push_back(mk(7'b0000000, 3'b010, 7'b0100000, 0, 0, 2'b00, 3'b000, 7'b0000000, 1'b0, 2, 0, 0, 0, 0, 0, 0, 1, 0)); // illegal
`ifdef MC_MEM_TIMEOUT_EN
        vq.push_back(mk(7'b0000011, 3'b010, 7'b0000000, 0, 1, 2'b00, 3'b010, 7'b0000000, 1'b1, 7, 0, 4, 0, 0, 0, 0, 0, 1)); // LW timeout
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_outputs",
            32'({ALUOp, Funct3, Funct7, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump, illegal, busy}),
            32'd0);
`ifdef MC_MEM_TIMEOUT_EN
        chk("reset_mem_err", 32'(mem_err), 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

        // Reset in the middle of MEM aborts the load
        @(negedge clk);
        instr_valid = 1'b1; opcode = 7'b0000011; funct3_in = 3'b000; funct7_in = 7'b0000000;
        @(negedge clk);               // cycle 1 (DECODE)
        instr_valid = 1'b0;
        @(negedge clk);               // cycle 2 (EXEC)
        @(negedge clk);               // cycle 3 (MEM)
        chk("rstmem_memread_before", 32'({MemRead, busy, Funct3}), 32'({1'b1, 1'b1, 3'b010}));
        #2 reset = 1'b1;
        #1;
        chk("rstmem_ready", 32'(instr_ready), 32'd1);
        chk("rstmem_outputs",
            32'({ALUOp, Funct3, Funct7, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump, illegal, busy}),
            32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;               // late ack after abort must not revive anything
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstmem_quiet%0d", c),
                32'({RegWrite, MemWrite, MemRead, busy, instr_ready}), 32'b00001);
        end
        mem_ack = 1'b0;

        if (exp_q.size() != 0) chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Watchdog: every wait above is bounded, this only catches a broken clock
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
